// File: rtl/pswd_change_writer.sv
// pswd_change_writer
//   Write side of the credential store. An authenticated user requests a
//   password change, types the new DIGITS-digit hex password twice, and on a
//   match a single WrReq/WrAck write of {WrID, WrData} is issued.
//
//   Optional feature macro: PSWD_CHANGE_LOCKOUT_EN adds a Locked output that
//   blocks further change requests after three mismatches until logout.
//
// Ports
//   Clk, Reset (async, active-low)
//   Successful, PlayerID           authentication status and user ID
//   InputSwitches, EnterPswd       hex digit and its enter pulse
//   LogOutPulse, ChangeReq         logout and change-request pulses
//   WrAck / WrReq, WrID, WrData    write handshake to the credential store
//   Busy, Stage, DigitCount        progress for the prompt display
//   Done, Mismatch, Aborted, Denied  single-cycle status pulses
//   Locked                         (lockout builds only)
module pswd_change_writer #(
  parameter int unsigned DIGITS         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter logic [4:0]  GUEST_ID       = 5'd31
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Successful,
  input  logic [4:0]            PlayerID,
  input  logic [3:0]            InputSwitches,
  input  logic                  EnterPswd,
  input  logic                  LogOutPulse,
  input  logic                  ChangeReq,
  input  logic                  WrAck,
  output logic                  WrReq,
  output logic [4:0]            WrID,
  output logic [4*DIGITS-1:0]   WrData,
  output logic                  Busy,
  output logic [1:0]            Stage,
  output logic [2:0]            DigitCount,
  output logic                  Done,
  output logic                  Mismatch,
  output logic                  Aborted,
  output logic                  Denied
`ifdef PSWD_CHANGE_LOCKOUT_EN
  ,
  output logic                  Locked
`endif
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [2:0]    DLAST = 3'(DIGITS - 1);
  localparam logic [2:0]    DFULL = 3'(DIGITS);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTER1, S_ENTER2, S_COMPARE, S_WRITE
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] buf1_q, buf1_d, buf2_q, buf2_d, wr_data_q, wr_data_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    wr_id_q, wr_id_d;
  logic          wr_req_q, wr_req_d;
  logic          done_q, done_d, mism_q, mism_d, abrt_q, abrt_d, deny_q, deny_d;
  logic          locked;
  logic          abort;

`ifdef PSWD_CHANGE_LOCKOUT_EN
  logic [1:0] mm_cnt_q, mm_cnt_d;
  assign locked = (mm_cnt_q == 2'd3);
  assign Locked = locked;
`else
  assign locked = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      buf1_q    <= '0;
      buf2_q    <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      wr_id_q   <= '0;
      wr_req_q  <= 1'b0;
      done_q    <= 1'b0;
      mism_q    <= 1'b0;
      abrt_q    <= 1'b0;
      deny_q    <= 1'b0;
`ifdef PSWD_CHANGE_LOCKOUT_EN
      mm_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      buf1_q    <= buf1_d;
      buf2_q    <= buf2_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      wr_id_q   <= wr_id_d;
      wr_req_q  <= wr_req_d;
      done_q    <= done_d;
      mism_q    <= mism_d;
      abrt_q    <= abrt_d;
      deny_q    <= deny_d;
`ifdef PSWD_CHANGE_LOCKOUT_EN
      mm_cnt_q  <= mm_cnt_d;
`endif
    end
  end

  // The timeout term only matters while digits are being entered; in
  // COMPARE the timer is already cleared.
  assign abort = LogOutPulse || !Successful ||
                 (((state_q == S_ENTER1) || (state_q == S_ENTER2)) && (timer_q == TMAX));

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    buf1_d    = buf1_q;
    buf2_d    = buf2_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    timer_d   = '0;
    wr_id_d   = wr_id_q;
    wr_req_d  = wr_req_q;
    done_d    = 1'b0;
    mism_d    = 1'b0;
    abrt_d    = 1'b0;
    deny_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ChangeReq) begin
          if (Successful && (PlayerID != GUEST_ID) && !locked) begin
            wr_id_d = PlayerID;
            buf1_d  = '0;
            buf2_d  = '0;
            cnt_d   = '0;
            state_d = S_ENTER1;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      S_ENTER1, S_ENTER2: begin
        if (abort) begin
          abrt_d  = 1'b1;
          buf1_d  = '0;
          buf2_d  = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (EnterPswd) begin
          if (state_q == S_ENTER1) buf1_d = {buf1_q[DW-5:0], InputSwitches};
          else                     buf2_d = {buf2_q[DW-5:0], InputSwitches};
          if (cnt_q == DLAST) begin
            cnt_d   = (state_q == S_ENTER1) ? 3'd0 : DFULL;
            state_d = (state_q == S_ENTER1) ? S_ENTER2 : S_COMPARE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          timer_d = (timer_q == TMAX) ? timer_q : timer_q + 1'b1;
        end
      end
      S_COMPARE: begin
        if (abort) begin
          abrt_d  = 1'b1;
          buf1_d  = '0;
          buf2_d  = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (buf1_q == buf2_q) begin
          wr_data_d = buf1_q;
          wr_req_d  = 1'b1;
          state_d   = S_WRITE;
        end else begin
          mism_d  = 1'b1;
          buf1_d  = '0;
          buf2_d  = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (WrAck) begin
          wr_req_d = 1'b0;
          done_d   = 1'b1;
          buf1_d   = '0;
          buf2_d   = '0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef PSWD_CHANGE_LOCKOUT_EN
    mm_cnt_d = mm_cnt_q;
    if (LogOutPulse || done_d)            mm_cnt_d = '0;
    else if (mism_d && mm_cnt_q != 2'd3)  mm_cnt_d = mm_cnt_q + 2'd1;
`endif
  end

  // Outputs
  always_comb begin
    Busy       = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:   Stage = 2'd0;
      S_ENTER1: Stage = 2'd1;
      S_ENTER2: Stage = 2'd2;
      default:  Stage = 2'd3;
    endcase
    WrReq      = wr_req_q;
    WrID       = wr_id_q;
    WrData     = wr_data_q;
    DigitCount = cnt_q;
    Done       = done_q;
    Mismatch   = mism_q;
    Aborted    = abrt_q;
    Denied     = deny_q;
  end

endmodule

// File: tb/tb_pswd_change_writer.sv
module tb_pswd_change_writer;
  localparam int TO = 16;

  logic        Clk = 1'b0;
  logic        Reset, Successful, EnterPswd, LogOutPulse, ChangeReq, WrAck;
  logic [4:0]  PlayerID;
  logic [3:0]  InputSwitches;
  logic        WrReq, Busy, Done, Mismatch, Aborted, Denied;
  logic [4:0]  WrID;
  logic [23:0] WrData;
  logic [1:0]  Stage;
  logic [2:0]  DigitCount;
  logic        Locked;

  int checks = 0;
  int errors = 0;

  pswd_change_writer #(.DIGITS(6), .TIMEOUT_CYCLES(TO), .GUEST_ID(5'd31)) dut (
    .Clk(Clk), .Reset(Reset), .Successful(Successful), .PlayerID(PlayerID),
    .InputSwitches(InputSwitches), .EnterPswd(EnterPswd), .LogOutPulse(LogOutPulse),
    .ChangeReq(ChangeReq), .WrAck(WrAck), .WrReq(WrReq), .WrID(WrID), .WrData(WrData),
    .Busy(Busy), .Stage(Stage), .DigitCount(DigitCount), .Done(Done),
    .Mismatch(Mismatch), .Aborted(Aborted), .Denied(Denied)
`ifdef PSWD_CHANGE_LOCKOUT_EN
    , .Locked(Locked)
`endif
  );

`ifndef PSWD_CHANGE_LOCKOUT_EN
  assign Locked = 1'b0;
`endif

  always #5 Clk = ~Clk;

  // Reference model: phase 0 idle, 1 first entry, 2 confirm, 3 compare, 4 write
  int         m_phase, m_idle, m_mm;
  logic [3:0] m_q1[$];
  logic [3:0] m_q2[$];
  logic [4:0] m_id;
  logic [23:0] m_data;
  bit m_req, m_done, m_mism, m_abrt, m_deny;

  function automatic void model_reset();
    m_phase = 0; m_idle = 0; m_mm = 0;
    m_q1.delete(); m_q2.delete();
    m_id = '0; m_data = '0;
    m_req = 0; m_done = 0; m_mism = 0; m_abrt = 0; m_deny = 0;
  endfunction

  function automatic bit lock_active();
`ifdef PSWD_CHANGE_LOCKOUT_EN
    return m_mm >= 3;
`else
    return 0;
`endif
  endfunction

  function automatic void model_next();
    bit same;
    logic [23:0] v;
    if (!Reset) begin model_reset(); return; end
    m_done = 0; m_mism = 0; m_abrt = 0; m_deny = 0;
    case (m_phase)
      0: if (ChangeReq) begin
           if (Successful && PlayerID != 5'd31 && !lock_active()) begin
             m_id = PlayerID; m_q1.delete(); m_q2.delete(); m_idle = 0; m_phase = 1;
           end else m_deny = 1;
         end
      1, 2: begin
        if (LogOutPulse || !Successful || m_idle >= TO) begin
          m_abrt = 1; m_q1.delete(); m_q2.delete(); m_idle = 0; m_phase = 0;
        end else if (EnterPswd) begin
          m_idle = 0;
          if (m_phase == 1) begin
            m_q1.push_back(InputSwitches);
            if (m_q1.size() == 6) m_phase = 2;
          end else begin
            m_q2.push_back(InputSwitches);
            if (m_q2.size() == 6) m_phase = 3;
          end
        end else if (m_idle < TO) m_idle++;
      end
      3: begin
        if (LogOutPulse || !Successful) begin
          m_abrt = 1; m_q1.delete(); m_q2.delete(); m_phase = 0;
        end else begin
          same = 1; v = '0;
          for (int i = 0; i < 6; i++) begin
            if (m_q1[i] != m_q2[i]) same = 0;
            v = v * 16 + 24'(m_q1[i]);
          end
          if (same) begin m_data = v; m_req = 1; m_phase = 4; end
          else begin m_mism = 1; m_q1.delete(); m_q2.delete(); m_phase = 0; end
        end
      end
      default: if (WrAck) begin
        m_req = 0; m_done = 1; m_q1.delete(); m_q2.delete(); m_phase = 0;
      end
    endcase
    if (LogOutPulse || m_done) m_mm = 0;
    else if (m_mism && m_mm < 3) m_mm++;
  endfunction

  function automatic int exp_count();
    case (m_phase)
      1: return m_q1.size();
      2: return m_q2.size();
      3, 4: return 6;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("WrReq", 32'(WrReq), 32'(m_req));
    chk("WrID", 32'(WrID), 32'(m_id));
    chk("WrData", 32'(WrData), 32'(m_data));
    chk("Busy", 32'(Busy), 32'(m_phase != 0));
    chk("Stage", 32'(Stage), (m_phase >= 3) ? 32'd3 : 32'(m_phase));
    chk("DigitCount", 32'(DigitCount), 32'(exp_count()));
    chk("Done", 32'(Done), 32'(m_done));
    chk("Mismatch", 32'(Mismatch), 32'(m_mism));
    chk("Aborted", 32'(Aborted), 32'(m_abrt));
    chk("Denied", 32'(Denied), 32'(m_deny));
    chk("Locked", 32'(Locked), 32'(lock_active()));
  endtask

  task automatic step();
    model_next();
    @(posedge Clk);
    #1;
    compare_all();
  endtask

  task automatic cyc(input bit cr, input bit en, input bit lo, input bit ack, input logic [3:0] d);
    ChangeReq = cr; EnterPswd = en; LogOutPulse = lo; WrAck = ack; InputSwitches = d;
    step();
  endtask

  task automatic enter_pw(input logic [23:0] pw, input int ndig);
    for (int i = 0; i < ndig; i++) cyc(0, 1, 0, 0, pw[23-4*i -: 4]);
  endtask

  task automatic mismatch_round();
    cyc(1, 0, 0, 0, 0);
    enter_pw(24'hA54E32, 6);
    enter_pw(24'hA54E33, 6);
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    int quiet;
    bit cr, en, lo, ack;
    logic [3:0] d;

    Reset = 0; Successful = 1; PlayerID = 5'd1;
    ChangeReq = 0; EnterPswd = 0; LogOutPulse = 0; WrAck = 0; InputSwitches = 0;
    model_reset();
    #1;
    chk("reset_WrReq", 32'(WrReq), 0);
    chk("reset_WrData", 32'(WrData), 0);
    chk("reset_Busy", 32'(Busy), 0);
    step(); step();
    Reset = 1;
    step();

    // Full successful change with a stalled acknowledge
    cyc(1, 0, 0, 0, 0);
    chk("t1_stage1", 32'(Stage), 1);
    enter_pw(24'h123456, 6);
    chk("t1_stage2", 32'(Stage), 2);
    chk("t1_cnt_after_first", 32'(DigitCount), 0);
    enter_pw(24'h123456, 6);
    chk("t1_cnt_full", 32'(DigitCount), 6);
    cyc(0, 0, 0, 0, 0);
    chk("t1_WrReq", 32'(WrReq), 1);
    chk("t1_WrID", 32'(WrID), 1);
    chk("t1_WrData", 32'(WrData), 32'h123456);
    PlayerID = 5'd7;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    chk("t1_stall_WrReq", 32'(WrReq), 1);
    chk("t1_stall_WrID", 32'(WrID), 1);
    cyc(0, 0, 0, 1, 0);
    chk("t1_Done", 32'(Done), 1);
    chk("t1_WrReq_low", 32'(WrReq), 0);
    chk("t1_Busy", 32'(Busy), 0);
    cyc(0, 0, 0, 0, 0);
    chk("t1_Done_once", 32'(Done), 0);

    // Mismatched confirmation
    PlayerID = 5'd1;
    mismatch_round();
    chk("t2_Mismatch", 32'(Mismatch), 1);
    chk("t2_WrReq", 32'(WrReq), 0);
    chk("t2_Busy", 32'(Busy), 0);
    chk("t2_cnt", 32'(DigitCount), 0);

    // Refused requests
    Successful = 0;
    cyc(1, 0, 0, 0, 0);
    chk("t3_Denied_unauth", 32'(Denied), 1);
    chk("t3_Busy_unauth", 32'(Busy), 0);
    Successful = 1; PlayerID = 5'd31;
    cyc(1, 0, 0, 0, 0);
    chk("t3_Denied_guest", 32'(Denied), 1);
    chk("t3_Busy_guest", 32'(Busy), 0);
    PlayerID = 5'd2;

    // Logout beats a coincident digit
    cyc(1, 0, 0, 0, 0);
    enter_pw(24'h987654, 3);
    cyc(0, 1, 1, 0, 4'h6);
    chk("t4_Aborted", 32'(Aborted), 1);
    chk("t4_cnt", 32'(DigitCount), 0);
    chk("t4_WrReq", 32'(WrReq), 0);

    // Timeout after TO idle cycles in ENTER1
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) cyc(0, 0, 0, 0, 0);
    chk("t4_to_not_yet", 32'(Aborted), 0);
    chk("t4_to_busy", 32'(Busy), 1);
    cyc(0, 0, 0, 0, 0);
    chk("t4_to_Aborted", 32'(Aborted), 1);
    chk("t4_to_Busy", 32'(Busy), 0);

    // WRITE ignores logout and de-authentication
    cyc(1, 0, 0, 0, 0);
    enter_pw(24'hBEEF01, 6);
    enter_pw(24'hBEEF01, 6);
    cyc(0, 0, 0, 0, 0);
    Successful = 0;
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("t5_WrReq_held", 32'(WrReq), 1);
    cyc(0, 0, 0, 1, 0);
    chk("t5_Done", 32'(Done), 1);
    chk("t5_not_Aborted", 32'(Aborted), 0);
    chk("t5_WrData", 32'(WrData), 32'hBEEF01);
    Successful = 1;

    // Asynchronous reset in ENTER2
    cyc(1, 0, 0, 0, 0);
    enter_pw(24'h111111, 6);
    enter_pw(24'h222222, 3);
    #2 Reset = 0;
    #1;
    chk("t6_WrData", 32'(WrData), 0);
    chk("t6_WrID", 32'(WrID), 0);
    chk("t6_Busy", 32'(Busy), 0);
    chk("t6_Stage", 32'(Stage), 0);
    chk("t6_cnt", 32'(DigitCount), 0);
    model_reset();
    cyc(0, 0, 0, 0, 0);
    Reset = 1;
    cyc(0, 0, 0, 0, 0);

`ifdef PSWD_CHANGE_LOCKOUT_EN
    for (int r = 0; r < 3; r++) mismatch_round();
    chk("lk_Locked", 32'(Locked), 1);
    cyc(1, 0, 0, 0, 0);
    chk("lk_Denied", 32'(Denied), 1);
    chk("lk_Busy", 32'(Busy), 0);
    cyc(0, 0, 1, 0, 0);
    chk("lk_unlocked", 32'(Locked), 0);
`endif

    // Randomized traffic
    quiet = 0;
    for (int n = 0; n < 4000; n++) begin
      Successful = ($urandom_range(63) != 0);
      PlayerID   = ($urandom_range(7) == 0) ? 5'd31 : 5'($urandom_range(31));
      cr = ($urandom_range(3) == 0);
      if (quiet > 0) begin
        en = 0; quiet--;
      end else begin
        en = 1'($urandom_range(1));
        if ($urandom_range(59) == 0) quiet = 20;
      end
      if (m_phase == 2 && $urandom_range(7) != 0) d = m_q1[m_q2.size()];
      else d = 4'($urandom_range(15));
      lo  = ($urandom_range(99) == 0);
      ack = ($urandom_range(2) == 0);
      cyc(cr, en, lo, ack, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
